// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the MEM-stage Wishbone master: bus FSM state encodings,
// pipeline control constants and a small stall-vector helper.
package mem_bus_master_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE       = 2'b00,
    BUS_BUSY       = 2'b01,
    BUS_WAIT_STALL = 2'b11
  } bus_state_e;

  localparam logic RST_ENABLE = 1'b1;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam int   STALL_W    = 6;

  function automatic logic stall_active(input logic [STALL_W-1:0] stall);
    return (stall != {STALL_W{1'b0}});
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Wishbone classic bus bundle between the MEM-stage master and a memory slave.
interface mem_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic                wb_we_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_stb_o;
  logic                wb_cyc_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_bus_master.sv
// MEM-stage Wishbone classic master: one bus cycle per load/store request, stall
// request while outstanding, read data held through pipeline stalls, timeout abort.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  mem_bus_master_if.master    wb
);

  localparam logic [DATA_W-1:0]   ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0]   ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [DATA_W/8-1:0] ZERO_SEL  = {(DATA_W/8){1'b0}};
  localparam logic [TMO_W-1:0]    TMO_ZERO  = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0]    TMO_MAX   = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  bus_state_e          state_r, next_state_s;
  logic [ADDR_W-1:0]   adr_r;
  logic [DATA_W-1:0]   dat_r;
  logic                we_r;
  logic [DATA_W/8-1:0] sel_r;
  logic                stb_r;
  logic                cyc_r;
  logic [DATA_W-1:0]   rd_buf_r;
  logic [TMO_W-1:0]    tmo_cnt_r;
  logic                bus_err_r;
  logic                tmo_hit_s;
  logic                stallreq_s;
  logic [DATA_W-1:0]   cpu_data_s;

  assign tmo_hit_s = (TIMEOUT != 0) && (tmo_cnt_r == TMO_LAST);

  // Next-state decode plus the combinational stall request and load-data return.
  always_comb begin
    next_state_s = state_r;
    stallreq_s   = NO_STOP;
    cpu_data_s   = ZERO_DATA;
    case (state_r)
      BUS_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          next_state_s = BUS_BUSY;
          stallreq_s   = STOP;
        end else begin
          next_state_s = BUS_IDLE;
        end
      end
      BUS_BUSY: begin
        stallreq_s = (!wb.wb_ack_i && !flush_i) ? STOP : NO_STOP;
        if (wb.wb_ack_i && !we_r) begin
          cpu_data_s = wb.wb_dat_i;
        end else begin
          cpu_data_s = ZERO_DATA;
        end
        if (flush_i) begin
          next_state_s = BUS_IDLE;
        end else if (wb.wb_ack_i) begin
          next_state_s = stall_active(stall_i) ? BUS_WAIT_STALL : BUS_IDLE;
        end else if (tmo_hit_s) begin
          next_state_s = BUS_IDLE;
        end else begin
          next_state_s = BUS_BUSY;
        end
      end
      BUS_WAIT_STALL: begin
        cpu_data_s = rd_buf_r;
        if (!stall_active(stall_i) || flush_i) begin
          next_state_s = BUS_IDLE;
        end else begin
          next_state_s = BUS_WAIT_STALL;
        end
      end
      default: begin
        next_state_s = BUS_IDLE;
      end
    endcase
  end

  // State register, bus outputs, read buffer, timeout counter and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_r   <= BUS_IDLE;
      adr_r     <= ZERO_ADDR;
      dat_r     <= ZERO_DATA;
      we_r      <= 1'b0;
      sel_r     <= ZERO_SEL;
      stb_r     <= 1'b0;
      cyc_r     <= 1'b0;
      rd_buf_r  <= ZERO_DATA;
      tmo_cnt_r <= TMO_ZERO;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      bus_err_r <= 1'b0;
      case (state_r)
        BUS_IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            adr_r     <= cpu_addr_i;
            dat_r     <= cpu_data_i;
            we_r      <= cpu_we_i;
            sel_r     <= cpu_sel_i;
            stb_r     <= 1'b1;
            cyc_r     <= 1'b1;
            tmo_cnt_r <= TMO_ZERO;
          end
        end
        BUS_BUSY: begin
          if (flush_i) begin
            cyc_r    <= 1'b0;
            stb_r    <= 1'b0;
            we_r     <= 1'b0;
            rd_buf_r <= ZERO_DATA;
          end else if (wb.wb_ack_i) begin
            cyc_r    <= 1'b0;
            stb_r    <= 1'b0;
            we_r     <= 1'b0;
            // Stores leave the buffer zeroed so a stalled store returns no data.
            rd_buf_r <= we_r ? ZERO_DATA : wb.wb_dat_i;
          end else if (tmo_hit_s) begin
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            we_r      <= 1'b0;
            bus_err_r <= 1'b1;
          end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        BUS_WAIT_STALL: begin
          if (flush_i) begin
            rd_buf_r <= ZERO_DATA;
          end
        end
        default: begin
          cyc_r <= 1'b0;
          stb_r <= 1'b0;
          we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign wb.wb_adr_o = adr_r;
  assign wb.wb_dat_o = dat_r;
  assign wb.wb_we_o  = we_r;
  assign wb.wb_sel_o = sel_r;
  assign wb.wb_stb_o = stb_r;
  assign wb.wb_cyc_o = cyc_r;
  assign bus_err_o   = bus_err_r;
  assign stallreq_o  = stallreq_s;
  assign cpu_data_o  = cpu_data_s;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: table-driven accesses with a data
// scoreboard, plus hand sequences for back-to-back, flush, timeout and reset.
module tb_mem_bus_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [5:0]    stall_i;
  logic          flush_i;
  logic          cpu_ce_i;
  logic          cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [3:0]    cpu_sel_i;
  logic [DW-1:0] cpu_data_i;
  logic [DW-1:0] cpu_data_o;
  logic          stallreq_o;
  logic          bus_err_o;

  mem_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) wb ();

  mem_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .TMO_W(3)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o), .wb(wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          hold;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name, output logic [31:0] exp);
    n_tests++;
    exp = 32'hFFFF_FFFF;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0h", name, cpu_data_o);
    end else begin
      exp = sb.pop_front();
      if (cpu_data_o !== exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, cpu_data_o, exp, $time);
      end
    end
  endtask

  task automatic run_access(input vec_t v);
    logic [31:0] exp;
    cpu_ce_i   = 1'b1;
    cpu_we_i   = v.we;
    cpu_addr_i = v.addr;
    cpu_sel_i  = v.sel;
    cpu_data_i = v.wdata;
    sb.push_back(v.exp_data);
    @(negedge clk);
    check("ce_stallreq", {63'd0, stallreq_o}, 64'd1);
    step();
    // Scramble the request inputs: the latched bus values must not follow them.
    cpu_ce_i   = 1'b0;
    cpu_we_i   = ~v.we;
    cpu_addr_i = 32'hBAD0_0000;
    cpu_sel_i  = ~v.sel;
    cpu_data_i = ~v.wdata;
    for (int k = 0; k <= v.waits; k++) begin
      if (k == v.waits) begin
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = v.rdata;
        stall_i     = (v.hold > 0) ? 6'b011111 : 6'b000000;
      end
      @(negedge clk);
      check("busy_cyc", {63'd0, wb.wb_cyc_o}, 64'd1);
      check("busy_stb", {63'd0, wb.wb_stb_o}, 64'd1);
      check("busy_we", {63'd0, wb.wb_we_o}, {63'd0, v.we});
      check("busy_adr", {32'd0, wb.wb_adr_o}, {32'd0, v.addr});
      check("busy_sel", {60'd0, wb.wb_sel_o}, {60'd0, v.sel});
      check("busy_dat", {32'd0, wb.wb_dat_o}, {32'd0, v.wdata});
      check("busy_stallreq", {63'd0, stallreq_o}, (k == v.waits) ? 64'd0 : 64'd1);
      if (k == v.waits) begin
        pop_check("ack_data", exp);
      end
      step();
    end
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = 32'h0BAD_F00D;
    for (int j = 0; j < v.hold; j++) begin
      stall_i = (j < v.hold - 1) ? 6'b011111 : 6'b000000;
      @(negedge clk);
      check("wait_state", {62'd0, dut.state_r}, 64'd3);
      check("wait_data", {32'd0, cpu_data_o}, {32'd0, exp});
      check("wait_stallreq", {63'd0, stallreq_o}, 64'd0);
      check("wait_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
      step();
    end
    stall_i = 6'b000000;
    @(negedge clk);
    check("idle_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
    check("idle_stb", {63'd0, wb.wb_stb_o}, 64'd0);
    check("idle_data", {32'd0, cpu_data_o}, 64'd0);
    check("idle_stallreq", {63'd0, stallreq_o}, 64'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp;
    int          cyc_cnt;
    bit          done;
    stall_i = 6'd0; flush_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = 32'd0; cpu_sel_i = 4'd0; cpu_data_i = 32'd0;
    wb.wb_ack_i = 1'b0; wb.wb_dat_i = 32'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    check("rst_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
    check("rst_stb", {63'd0, wb.wb_stb_o}, 64'd0);
    check("rst_we", {63'd0, wb.wb_we_o}, 64'd0);
    check("rst_adr", {32'd0, wb.wb_adr_o}, 64'd0);
    check("rst_sel", {60'd0, wb.wb_sel_o}, 64'd0);
    check("rst_dat", {32'd0, wb.wb_dat_o}, 64'd0);
    check("rst_err", {63'd0, bus_err_o}, 64'd0);
    check("rst_stallreq", {63'd0, stallreq_o}, 64'd0);
    check("rst_data", {32'd0, cpu_data_o}, 64'd0);
    step();
    rst = 1'b0;

    //           we    addr           sel      wdata          rdata          waits hold exp
    vecs[0] = '{1'b0, 32'h0000_0040, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0100, 4'b0011, 32'h0000_1234, 32'hFFFF_FFFF, 2, 0, 32'h0000_0000};
    vecs[2] = '{1'b1, 32'h0000_0104, 4'b1100, 32'h5678_0000, 32'h1357_9BDF, 1, 1, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0200, 4'b1111, 32'h0000_0000, 32'hA5A5_5A5A, 0, 0, 32'hA5A5_5A5A};
    vecs[4] = '{1'b0, 32'h0000_0044, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1, 2, 32'hDEAD_BEEF};
    for (int i = 0; i < 5; i++) begin
      run_access(vecs[i]);
    end

    // Back-to-back: ce held high through the ack edge must not start a cycle there.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0300; cpu_sel_i = 4'hF;
    sb.push_back(32'h1111_2222);
    step();
    cpu_addr_i = 32'h0000_0304;
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h1111_2222;
    @(negedge clk);
    pop_check("b2b_data1", exp);
    step();
    wb.wb_ack_i = 1'b0;
    sb.push_back(32'h3333_4444);
    @(negedge clk);
    check("b2b_gap_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
    check("b2b_gap_stallreq", {63'd0, stallreq_o}, 64'd1);
    step();
    cpu_ce_i = 1'b0;
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h3333_4444;
    @(negedge clk);
    check("b2b_adr2", {32'd0, wb.wb_adr_o}, 64'h0000_0304);
    pop_check("b2b_data2", exp);
    step();
    wb.wb_ack_i = 1'b0;
    @(negedge clk);
    check("b2b_idle_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
    step();

    // Flush with ack in the same cycle: abandon, clear buffer, no error.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0500;
    step();
    cpu_ce_i = 1'b0;
    @(negedge clk);
    check("fl_busy_cyc", {63'd0, wb.wb_cyc_o}, 64'd1);
    step();
    flush_i = 1'b1; wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'hCAFE_BABE; stall_i = 6'b011111;
    @(negedge clk);
    check("fl_stallreq", {63'd0, stallreq_o}, 64'd0);
    step();
    flush_i = 1'b0; wb.wb_ack_i = 1'b0; stall_i = 6'd0;
    @(negedge clk);
    check("fl_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
    check("fl_stb", {63'd0, wb.wb_stb_o}, 64'd0);
    check("fl_err", {63'd0, bus_err_o}, 64'd0);
    check("fl_rdbuf", {32'd0, dut.rd_buf_r}, 64'd0);
    check("fl_state", {62'd0, dut.state_r}, 64'd0);
    check("fl_data", {32'd0, cpu_data_o}, 64'd0);
    step();

    // Timeout: slave silent, cycle held exactly TIMEOUT=4 cycles then error pulse.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0600;
    step();
    cpu_ce_i = 1'b0;
    cyc_cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (wb.wb_cyc_o) begin
        cyc_cnt++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    check("tmo_cycles", 64'(cyc_cnt), 64'd4);
    check("tmo_err", {63'd0, bus_err_o}, 64'd1);
    check("tmo_stb", {63'd0, wb.wb_stb_o}, 64'd0);
    check("tmo_stallreq", {63'd0, stallreq_o}, 64'd0);
    step();
    @(negedge clk);
    check("tmo_err_pulse", {63'd0, bus_err_o}, 64'd0);
    step();

    // Asynchronous reset in the middle of a store cycle.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0700;
    cpu_sel_i = 4'hF; cpu_data_i = 32'h0000_0077;
    step();
    cpu_ce_i = 1'b0;
    @(negedge clk);
    check("rb_busy_cyc", {63'd0, wb.wb_cyc_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rb_cyc", {63'd0, wb.wb_cyc_o}, 64'd0);
    check("rb_stb", {63'd0, wb.wb_stb_o}, 64'd0);
    check("rb_we", {63'd0, wb.wb_we_o}, 64'd0);
    check("rb_adr", {32'd0, wb.wb_adr_o}, 64'd0);
    check("rb_sel", {60'd0, wb.wb_sel_o}, 64'd0);
    check("rb_dat", {32'd0, wb.wb_dat_o}, 64'd0);
    check("rb_err", {63'd0, bus_err_o}, 64'd0);
    step();
    rst = 1'b0;
    run_access('{1'b0, 32'h0000_0800, 4'b1111, 32'h0000_0000, 32'h5A5A_0001, 1, 0, 32'h5A5A_0001});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
